// File: rtl/idp_pkg.sv
// Shared types and constants for the integer data path sequencer.
// Optional overlap of WRITE with the next accept is enabled by IDP_SEQ_OVERLAP_EN.
package idp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_EXECUTE = 2'd2,
    ST_WRITE   = 2'd3
  } idp_state_e;

  // Instruction word field positions (LSB of each field)
  localparam int OP_LSB   = 27;
  localparam int WA_LSB   = 22;
  localparam int RA_LSB   = 17;
  localparam int SA_LSB   = 12;
  localparam int SSEL_LSB = 10;
  localparam int YSEL_BIT = 9;
  localparam int BSEL_LSB = 5;
  localparam int SAMT_LSB = 0;

  localparam logic [4:0] NOP_OP_DEF   = 5'h1F;
  localparam logic [3:0] FLAG_RST_DEF = 4'b0000;

  // Bit positions inside the {C,N,Z,V} status register
  localparam int FLG_C = 3;
  localparam int FLG_N = 2;
  localparam int FLG_Z = 1;
  localparam int FLG_V = 0;

  typedef struct packed {
    logic [4:0] alu_op;
    logic [4:0] w_addr;
    logic [4:0] r_addr;
    logic [4:0] s_addr;
    logic [1:0] s_sel;
    logic       y_sel;
    logic [3:0] b_sel;
    logic [4:0] samt;
  } idp_ctrl_t;

endpackage

// File: rtl/idp_sequencer_if.sv
// Instruction handshake, flag inputs and control outputs of the sequencer.
interface idp_sequencer_if;
  logic        ir_valid;
  logic [31:0] ir;
  logic        ir_ready;
  logic        C, N, Z, V;
  logic        W_En;
  logic [4:0]  W_Addr, R_Addr, S_Addr;
  logic [4:0]  ALU_Op;
  logic [1:0]  S_Sel;
  logic        Y_Sel;
  logic [3:0]  B_Sel;
  logic [4:0]  samt;
  logic [3:0]  flags;
  logic        done;

  modport master (
    output ir_valid, ir, C, N, Z, V,
    input  ir_ready, W_En, W_Addr, R_Addr, S_Addr, ALU_Op, S_Sel, Y_Sel,
           B_Sel, samt, flags, done
  );

  modport slave (
    input  ir_valid, ir, C, N, Z, V,
    output ir_ready, W_En, W_Addr, R_Addr, S_Addr, ALU_Op, S_Sel, Y_Sel,
           B_Sel, samt, flags, done
  );
endinterface

// File: rtl/idp_ir_decode.sv
// Combinational splitter from the 32-bit instruction word to control fields.
module idp_ir_decode
  import idp_pkg::*;
(
  input  logic [31:0] i_ir,
  output idp_ctrl_t   o_ctrl
);
  assign o_ctrl.alu_op = i_ir[OP_LSB   +: 5];
  assign o_ctrl.w_addr = i_ir[WA_LSB   +: 5];
  assign o_ctrl.r_addr = i_ir[RA_LSB   +: 5];
  assign o_ctrl.s_addr = i_ir[SA_LSB   +: 5];
  assign o_ctrl.s_sel  = i_ir[SSEL_LSB +: 2];
  assign o_ctrl.y_sel  = i_ir[YSEL_BIT];
  assign o_ctrl.b_sel  = i_ir[BSEL_LSB +: 4];
  assign o_ctrl.samt   = i_ir[SAMT_LSB +: 5];
endmodule

// File: rtl/idp_sequencer.sv
// DECODE/EXECUTE/WRITE sequencer feeding the integer data path; all outputs registered.
// Define IDP_SEQ_OVERLAP_EN to accept the next word during WRITE (3-cycle throughput).
module idp_sequencer
  import idp_pkg::*;
#(
  parameter logic [4:0] NOP_OP   = NOP_OP_DEF,
  parameter logic [3:0] FLAG_RST = FLAG_RST_DEF
) (
  input logic            clk,
  input logic            reset,
  idp_sequencer_if.slave bus
);

  idp_state_e  r_state;
  logic [31:0] r_ir;
  logic        w_accept;
  logic [31:0] w_word;
  idp_ctrl_t   w_ctrl;

  // Handshakes only happen in IDLE (or WRITE with overlap); otherwise decode the held word.
  assign w_accept = bus.ir_valid && bus.ir_ready;
  assign w_word   = w_accept ? bus.ir : r_ir;

  idp_ir_decode u_dec (
    .i_ir   (w_word),
    .o_ctrl (w_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_ir         <= '0;
      bus.ir_ready <= 1'b1;
      bus.W_En     <= 1'b0;
      bus.done     <= 1'b0;
      bus.W_Addr   <= '0;
      bus.R_Addr   <= '0;
      bus.S_Addr   <= '0;
      bus.ALU_Op   <= '0;
      bus.S_Sel    <= '0;
      bus.Y_Sel    <= 1'b0;
      bus.B_Sel    <= '0;
      bus.samt     <= '0;
      bus.flags    <= FLAG_RST;
    end else begin
      bus.W_En <= 1'b0;
      bus.done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
        end
        ST_DECODE: begin
          if (w_ctrl.alu_op == NOP_OP) begin
            bus.done     <= 1'b1;
            bus.ir_ready <= 1'b1;
            r_state      <= ST_IDLE;
          end else begin
            bus.ALU_Op <= w_ctrl.alu_op;
            bus.S_Sel  <= w_ctrl.s_sel;
            bus.Y_Sel  <= w_ctrl.y_sel;
            bus.B_Sel  <= w_ctrl.b_sel;
            bus.samt   <= w_ctrl.samt;
            r_state    <= ST_EXECUTE;
          end
        end
        ST_EXECUTE: begin
          bus.W_En <= 1'b1;
          r_state  <= ST_WRITE;
`ifdef IDP_SEQ_OVERLAP_EN
          bus.ir_ready <= 1'b1;
`else
          bus.ir_ready <= 1'b0;
`endif
        end
        ST_WRITE: begin
          bus.flags[FLG_C] <= bus.C;
          bus.flags[FLG_N] <= bus.N;
          bus.flags[FLG_Z] <= bus.Z;
          bus.flags[FLG_V] <= bus.V;
          bus.done         <= 1'b1;
          bus.ir_ready     <= 1'b1;
          r_state          <= ST_IDLE;
        end
        default: begin
          bus.ir_ready <= 1'b1;
          r_state      <= ST_IDLE;
        end
      endcase

      // A new word overrides the state update above and loads its addresses immediately.
      if (w_accept) begin
        r_ir         <= bus.ir;
        bus.ir_ready <= 1'b0;
        bus.W_Addr   <= w_ctrl.w_addr;
        bus.R_Addr   <= w_ctrl.r_addr;
        bus.S_Addr   <= w_ctrl.s_addr;
        r_state      <= ST_DECODE;
      end
    end
  end

endmodule

// File: tb/tb_idp_sequencer.sv
// Self-checking bench for idp_sequencer: directed scenarios plus a random stream vs a latency model.
module tb_idp_sequencer;
  import idp_pkg::*;

`ifdef IDP_SEQ_OVERLAP_EN
  localparam int PERIOD = 3;
`else
  localparam int PERIOD = 4;
`endif
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  logic reset;
  idp_sequencer_if bus();

  idp_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: edge-indexed schedule of pulses and field updates.
  int          cyc = -1;
  int          next_acc = 0;
  int          pend_exec = -1;
  int          flag_edge = -1;
  bit          exp_wen  [NCYC];
  bit          exp_done [NCYC];
  logic [14:0] exp_addr;
  logic [16:0] exp_ctl, pend_ctl;
  logic [3:0]  exp_flags;
  bit          m_acc;
  int          wen_seen[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    logic [4:0] op;
    @(posedge clk);
    cyc++;
    m_acc = 1'b0;
    if (reset) begin
      exp_addr  = '0;
      exp_ctl   = '0;
      exp_flags = 4'b0000;
      next_acc  = cyc + 1;
      pend_exec = -1;
      flag_edge = -1;
      for (int i = 0; i < 6; i++) begin
        exp_wen[cyc+i]  = 1'b0;
        exp_done[cyc+i] = 1'b0;
      end
    end else begin
      if (pend_exec == cyc) exp_ctl = pend_ctl;
      if (flag_edge == cyc) exp_flags = {bus.C, bus.N, bus.Z, bus.V};
      if (bus.ir_valid && cyc >= next_acc) begin
        m_acc    = 1'b1;
        op       = bus.ir[31:27];
        exp_addr = {bus.ir[26:22], bus.ir[21:17], bus.ir[16:12]};
        if (op == 5'h1F) begin
          exp_done[cyc+1] = 1'b1;
          next_acc        = cyc + 2;
        end else begin
          pend_exec       = cyc + 1;
          pend_ctl        = {bus.ir[31:27], bus.ir[11:0]};
          exp_wen[cyc+2]  = 1'b1;
          exp_done[cyc+3] = 1'b1;
          flag_edge       = cyc + 3;
          next_acc        = cyc + PERIOD;
        end
      end
    end
    #1;
    if (bus.W_En === 1'b1) wen_seen.push_back(cyc);
    chk("ir_ready", 32'(bus.ir_ready), 32'(cyc + 1 >= next_acc));
    chk("W_En",     32'(bus.W_En),     32'(exp_wen[cyc]));
    chk("done",     32'(bus.done),     32'(exp_done[cyc]));
    chk("flags",    32'(bus.flags),    32'(exp_flags));
    chk("addrs",    32'({bus.W_Addr, bus.R_Addr, bus.S_Addr}), 32'(exp_addr));
    chk("ctrl",     32'({bus.ALU_Op, bus.S_Sel, bus.Y_Sel, bus.B_Sel, bus.samt}), 32'(exp_ctl));
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom();
    if ($urandom_range(0, 3) == 0) w[31:27] = 5'h1F;
    return w;
  endfunction

  initial begin
    logic [31:0] words [3];
    int          idx;

    reset        = 1'b1;
    bus.ir_valid = 1'b0;
    bus.ir       = '0;
    {bus.C, bus.N, bus.Z, bus.V} = 4'b0000;
    step();
    step();
    chk("rst_ready", 32'(bus.ir_ready), 32'd1);
    chk("rst_flags", 32'(bus.flags), 32'd0);
    reset = 1'b0;

    // Single instruction
    bus.ir       = {5'h02, 5'd7, 5'd3, 5'd4, 2'b00, 1'b0, 4'h0, 5'd0};
    bus.ir_valid = 1'b1;
    step();
    chk("single_raddr", 32'(bus.R_Addr), 32'd3);
    chk("single_saddr", 32'(bus.S_Addr), 32'd4);
    chk("single_waddr", 32'(bus.W_Addr), 32'd7);
    bus.ir_valid = 1'b0;
    step();
    chk("single_alu", 32'(bus.ALU_Op), 32'd2);
    step();
    chk("single_wen", 32'(bus.W_En), 32'd1);
    step();
    chk("single_done", 32'(bus.done), 32'd1);
    step();

    // NOP: done after one cycle, no write
    bus.ir       = {5'h1F, 27'h2A5_5A5A};
    bus.ir_valid = 1'b1;
    step();
    bus.ir_valid = 1'b0;
    step();
    chk("nop_done", 32'(bus.done), 32'd1);
    chk("nop_wen",  32'(bus.W_En), 32'd0);
    step();

    // Flags latched leaving WRITE, ignored in IDLE
    {bus.C, bus.N, bus.Z, bus.V} = 4'b1010;
    bus.ir       = {5'h05, 5'd0, 5'd1, 5'd2, 2'b11, 1'b1, 4'h9, 5'd17};
    bus.ir_valid = 1'b1;
    step();
    bus.ir_valid = 1'b0;
    step();
    step();
    step();
    chk("flags_latch", 32'(bus.flags), 32'b1010);
    {bus.C, bus.N, bus.Z, bus.V} = 4'b0101;
    step();
    step();
    chk("flags_idle_hold", 32'(bus.flags), 32'b1010);

    // Reset while in EXECUTE
    bus.ir       = {5'h03, 5'd9, 5'd8, 5'd7, 2'b01, 1'b0, 4'h2, 5'd3};
    bus.ir_valid = 1'b1;
    step();
    bus.ir_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_exec_flags", 32'(bus.flags), 32'(FLAG_RST_DEF));
    wen_seen.delete();
    repeat (4) step();
    chk("rst_exec_no_wen", 32'(wen_seen.size()), 32'd0);

    // Back-to-back: valid held over three words
    for (int i = 0; i < 3; i++) words[i] = {5'(i + 1), 5'(i + 10), 22'($urandom())};
    idx          = 0;
    bus.ir       = words[0];
    bus.ir_valid = 1'b1;
    wen_seen.delete();
    for (int n = 0; n < 20; n++) begin
      step();
      if (m_acc) begin
        idx++;
        if (idx == 3) bus.ir_valid = 1'b0;
        else bus.ir = words[idx];
      end
    end
    chk("b2b_pulses", 32'(wen_seen.size()), 32'd3);
    if (wen_seen.size() == 3) begin
      chk("b2b_gap0", 32'(wen_seen[1] - wen_seen[0]), 32'(PERIOD));
      chk("b2b_gap1", 32'(wen_seen[2] - wen_seen[1]), 32'(PERIOD));
    end

    // Random stream with sporadic resets
    for (int n = 0; n < 400; n++) begin
      if (!bus.ir_valid && $urandom_range(0, 2) != 0) begin
        bus.ir       = rnd_word();
        bus.ir_valid = 1'b1;
      end
      {bus.C, bus.N, bus.Z, bus.V} = 4'($urandom());
      reset = ($urandom_range(0, 40) == 0);
      step();
      if (m_acc) bus.ir_valid = 1'b0;
    end
    reset        = 1'b0;
    bus.ir_valid = 1'b0;
    repeat (6) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
